// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: three-master round-robin Wishbone arbiter sharing one slave port.
// A grant is held for the whole transfer. The slave ack goes only to the granted master.
// A per-transfer watchdog aborts a transfer that the slave never acks.
module wb_rr_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  // m0: CPU instruction bus
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat,
  input  logic [DW/8-1:0] m0_sel,
  input  logic            m0_we,
  input  logic            m0_cyc,
  output logic [DW-1:0]   m0_rdt,
  output logic            m0_ack,
  output logic            m0_err,
  // m1: CPU data bus
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat,
  input  logic [DW/8-1:0] m1_sel,
  input  logic            m1_we,
  input  logic            m1_cyc,
  output logic [DW-1:0]   m1_rdt,
  output logic            m1_ack,
  output logic            m1_err,
  // m2: auxiliary master (loader / debug)
  input  logic [AW-1:0]   m2_adr,
  input  logic [DW-1:0]   m2_dat,
  input  logic [DW/8-1:0] m2_sel,
  input  logic            m2_we,
  input  logic            m2_cyc,
  output logic [DW-1:0]   m2_rdt,
  output logic            m2_ack,
  output logic            m2_err,
  // Shared slave port
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat,
  output logic [DW/8-1:0] s_sel,
  output logic            s_we,
  output logic            s_cyc,
  input  logic [DW-1:0]   s_rdt,
  input  logic            s_ack,
  output logic [2:0]      grant
);

  // Counter is at least one bit wide so a disabled watchdog still elaborates.
  localparam int unsigned   CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CntLast = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CntMax  = CW'(TIMEOUT);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e        r_state;
  logic [2:0]    r_grant;
  logic [1:0]    r_idx;
  logic [1:0]    r_last;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_err;

  logic [2:0]    w_cyc;
  logic          w_gnt_cyc;
  logic          w_timeout;
  logic [1:0]    w_cand0;
  logic [1:0]    w_cand1;
  logic [1:0]    w_cand2;
  logic [1:0]    w_pick;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  assign w_cyc     = {m2_cyc, m1_cyc, m0_cyc};
  assign w_gnt_cyc = |(w_cyc & r_grant);
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CntLast);

  // Rotating priority: the search starts one past the last master served.
  always_comb begin
    w_cand0 = next_idx(r_last);
    w_cand1 = next_idx(w_cand0);
    w_cand2 = r_last;
    if (w_cyc[w_cand0]) begin
      w_pick = w_cand0;
    end else if (w_cyc[w_cand1]) begin
      w_pick = w_cand1;
    end else begin
      w_pick = w_cand2;
    end
  end

  // Forward the granted master's request; all zero while nothing is granted.
  always_comb begin
    s_adr = '0;
    s_dat = '0;
    s_sel = '0;
    s_we  = 1'b0;
    unique case (r_grant)
      3'b001: begin
        s_adr = m0_adr;
        s_dat = m0_dat;
        s_sel = m0_sel;
        s_we  = m0_we;
      end
      3'b010: begin
        s_adr = m1_adr;
        s_dat = m1_dat;
        s_sel = m1_sel;
        s_we  = m1_we;
      end
      3'b100: begin
        s_adr = m2_adr;
        s_dat = m2_dat;
        s_sel = m2_sel;
        s_we  = m2_we;
      end
      default: ;
    endcase
  end

  // Grant is cleared on the watchdog abort edge, so s_cyc drops with it.
  assign s_cyc = w_gnt_cyc;
  assign grant = r_grant;

  // Ack is combinational from the slave; grant is only non-zero while busy.
  assign m0_ack = r_grant[0] & s_ack;
  assign m1_ack = r_grant[1] & s_ack;
  assign m2_ack = r_grant[2] & s_ack;

  assign m0_err = r_err[0];
  assign m1_err = r_err[1];
  assign m2_err = r_err[2];

  assign m0_rdt = s_rdt;
  assign m1_rdt = s_rdt;
  assign m2_rdt = s_rdt;

  // Arbitration FSM: grant, round-robin pointer, watchdog counter and error pulse.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_idx   <= 2'd0;
      r_last  <= 2'd2;
      r_cnt   <= '0;
      r_err   <= '0;
    end else begin
      r_err <= '0;
      unique case (r_state)
        StIdle: begin
          if (|w_cyc) begin
            r_state <= StBusy;
            r_grant <= 3'b001 << w_pick;
            r_idx   <= w_pick;
            r_cnt   <= '0;
          end
        end
        StBusy: begin
          if (s_ack) begin
            // Ack wins over a coincident timeout.
            r_state <= StIdle;
            r_grant <= '0;
            r_last  <= r_idx;
          end else if (!w_gnt_cyc) begin
            // Master abort: no ack, no err.
            r_state <= StIdle;
            r_grant <= '0;
            r_last  <= r_idx;
          end else if (w_timeout) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_last  <= r_idx;
            r_err   <= r_grant;
          end else if (r_cnt != CntMax) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: table vectors, hand sequences and a randomized run against a reference model.
module tb_wb_rr_arbiter;

  localparam int unsigned TO = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;

  logic [31:0] adr [3];
  logic [31:0] dat [3];
  logic [3:0]  sel [3];
  logic [2:0]  we;
  logic [2:0]  cyc;
  logic [31:0] rdt [3];
  logic [2:0]  ack;
  logic [2:0]  err;

  logic [31:0] s_adr;
  logic [31:0] s_dat;
  logic [3:0]  s_sel;
  logic        s_we;
  logic        s_cyc;
  logic [31:0] s_rdt;
  logic        s_ack;
  logic [2:0]  grant;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .AW      (32),
    .DW      (32),
    .TIMEOUT (TO)
  ) dut (
    .wb_clk   (clk),
    .wb_rst_n (rst_n),
    .m0_adr   (adr[0]),
    .m0_dat   (dat[0]),
    .m0_sel   (sel[0]),
    .m0_we    (we[0]),
    .m0_cyc   (cyc[0]),
    .m0_rdt   (rdt[0]),
    .m0_ack   (ack[0]),
    .m0_err   (err[0]),
    .m1_adr   (adr[1]),
    .m1_dat   (dat[1]),
    .m1_sel   (sel[1]),
    .m1_we    (we[1]),
    .m1_cyc   (cyc[1]),
    .m1_rdt   (rdt[1]),
    .m1_ack   (ack[1]),
    .m1_err   (err[1]),
    .m2_adr   (adr[2]),
    .m2_dat   (dat[2]),
    .m2_sel   (sel[2]),
    .m2_we    (we[2]),
    .m2_cyc   (cyc[2]),
    .m2_rdt   (rdt[2]),
    .m2_ack   (ack[2]),
    .m2_err   (err[2]),
    .s_adr    (s_adr),
    .s_dat    (s_dat),
    .s_sel    (s_sel),
    .s_we     (s_we),
    .s_cyc    (s_cyc),
    .s_rdt    (s_rdt),
    .s_ack    (s_ack),
    .grant    (grant)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  // Owner of the bus (if any), BUSY cycles elapsed, last served master, pending error pulse.
  logic       mo_busy;
  logic [1:0] mo_owner;
  logic [1:0] mo_last;
  int         mo_cycles;
  logic       mo_errv;
  logic [1:0] mo_errp;

  logic [2:0]  e_g;
  logic [2:0]  e_a;
  logic [2:0]  e_e;
  logic        e_scyc;
  logic [31:0] e_adr;
  logic [31:0] e_dat;
  logic [3:0]  e_sel;
  logic        e_we;

  task automatic model_reset();
    mo_busy   = 1'b0;
    mo_owner  = 2'd0;
    mo_last   = 2'd2;
    mo_cycles = 0;
    mo_errv   = 1'b0;
    mo_errp   = 2'd0;
  endtask

  task automatic model_check();
    e_g = 3'b000; e_a = 3'b000; e_e = 3'b000; e_scyc = 1'b0;
    e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0;
    if (mo_busy) begin
      e_g    = 3'(1 << mo_owner);
      e_scyc = cyc[mo_owner];
      e_adr  = adr[mo_owner];
      e_dat  = dat[mo_owner];
      e_sel  = sel[mo_owner];
      e_we   = we[mo_owner];
      e_a    = s_ack ? e_g : 3'b000;
    end
    if (mo_errv) e_e = 3'(1 << mo_errp);
    chk("rand grant", 64'(grant), 64'(e_g));
    chk("rand s_cyc", 64'(s_cyc), 64'(e_scyc));
    chk("rand s_adr", 64'(s_adr), 64'(e_adr));
    chk("rand s_dat", 64'(s_dat), 64'(e_dat));
    chk("rand s_sel_we", 64'({s_sel, s_we}), 64'({e_sel, e_we}));
    chk("rand ack", 64'(ack), 64'(e_a));
    chk("rand err", 64'(err), 64'(e_e));
    chk("rand m0_rdt", 64'(rdt[0]), 64'(s_rdt));
    chk("rand m1_rdt", 64'(rdt[1]), 64'(s_rdt));
    chk("rand m2_rdt", 64'(rdt[2]), 64'(s_rdt));
  endtask

  task automatic model_step();
    logic       found;
    logic [1:0] cand;
    mo_errv = 1'b0;
    if (!mo_busy) begin
      if (|cyc) begin
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          cand = 2'((int'(mo_last) + k) % 3);
          if (!found && cyc[cand]) begin
            found    = 1'b1;
            mo_owner = cand;
          end
        end
        mo_busy   = 1'b1;
        mo_cycles = 0;
      end
    end else begin
      mo_cycles++;
      if (s_ack || !cyc[mo_owner]) begin
        mo_busy = 1'b0;
        mo_last = mo_owner;
      end else if (TO != 0 && mo_cycles == int'(TO)) begin
        mo_busy = 1'b0;
        mo_last = mo_owner;
        mo_errv = 1'b1;
        mo_errp = mo_owner;
      end
    end
  endtask

  // ---------------- Vector table ----------------
  typedef struct {
    logic [2:0] cyc;
    logic       sack;
    logic [2:0] g;
    logic       scyc;
    logic [2:0] a;
    logic [2:0] e;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];

  function automatic vec_t v(input logic [2:0] c, input logic sa, input logic [2:0] g,
                             input logic sc, input logic [2:0] a, input logic [2:0] e);
    vec_t r;
    r.cyc = c; r.sack = sa; r.g = g; r.scyc = sc; r.a = a; r.e = e;
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    cyc   = 3'b000;
    we    = 3'b000;
    s_ack = 1'b0;
    s_rdt = '0;
    for (logic [1:0] n = 2'd0; n != 2'd3; n++) begin
      adr[n] = '0; dat[n] = '0; sel[n] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("reset grant", 64'(grant), 64'(0));
    chk("reset s_cyc", 64'(s_cyc), 64'(0));
    chk("reset ack_err", 64'({ack, err}), 64'(0));
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] x_adr;
    logic [2:0]  done;

    // Fairness, master abort, timeout, ack/timeout collision, abort with pending m1.
    vecs[0]  = v(3'b111, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[1]  = v(3'b111, 1'b0, 3'b001, 1'b1, 3'b000, 3'b000);
    vecs[2]  = v(3'b111, 1'b1, 3'b001, 1'b1, 3'b001, 3'b000);
    vecs[3]  = v(3'b111, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[4]  = v(3'b111, 1'b0, 3'b010, 1'b1, 3'b000, 3'b000);
    vecs[5]  = v(3'b111, 1'b1, 3'b010, 1'b1, 3'b010, 3'b000);
    vecs[6]  = v(3'b111, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[7]  = v(3'b111, 1'b0, 3'b100, 1'b1, 3'b000, 3'b000);
    vecs[8]  = v(3'b111, 1'b1, 3'b100, 1'b1, 3'b100, 3'b000);
    vecs[9]  = v(3'b111, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[10] = v(3'b111, 1'b1, 3'b001, 1'b1, 3'b001, 3'b000);
    vecs[11] = v(3'b111, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[12] = v(3'b111, 1'b0, 3'b010, 1'b1, 3'b000, 3'b000);
    vecs[13] = v(3'b000, 1'b0, 3'b010, 1'b0, 3'b000, 3'b000);
    vecs[14] = v(3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[15] = v(3'b100, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[16] = v(3'b100, 1'b0, 3'b100, 1'b1, 3'b000, 3'b000);
    vecs[17] = v(3'b100, 1'b0, 3'b100, 1'b1, 3'b000, 3'b000);
    vecs[18] = v(3'b100, 1'b0, 3'b100, 1'b1, 3'b000, 3'b000);
    vecs[19] = v(3'b100, 1'b0, 3'b100, 1'b1, 3'b000, 3'b000);
    vecs[20] = v(3'b100, 1'b0, 3'b000, 1'b0, 3'b000, 3'b100);
    vecs[21] = v(3'b000, 1'b0, 3'b100, 1'b0, 3'b000, 3'b000);
    vecs[22] = v(3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[23] = v(3'b100, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[24] = v(3'b100, 1'b0, 3'b100, 1'b1, 3'b000, 3'b000);
    vecs[25] = v(3'b100, 1'b0, 3'b100, 1'b1, 3'b000, 3'b000);
    vecs[26] = v(3'b100, 1'b0, 3'b100, 1'b1, 3'b000, 3'b000);
    vecs[27] = v(3'b100, 1'b1, 3'b100, 1'b1, 3'b100, 3'b000);
    vecs[28] = v(3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[29] = v(3'b011, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[30] = v(3'b010, 1'b0, 3'b001, 1'b0, 3'b000, 3'b000);
    vecs[31] = v(3'b010, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[32] = v(3'b010, 1'b1, 3'b010, 1'b1, 3'b010, 3'b000);
    vecs[33] = v(3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);

    do_reset();
    adr[0] = 32'h0000_1000;
    adr[1] = 32'h0000_2000;
    adr[2] = 32'h0000_3000;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      cyc   = vecs[i].cyc;
      s_ack = vecs[i].sack;
      #2;
      x_adr = vecs[i].g[0] ? 32'h0000_1000 : vecs[i].g[1] ? 32'h0000_2000 :
              vecs[i].g[2] ? 32'h0000_3000 : 32'h0;
      chk($sformatf("vec%0d grant", i), 64'(grant), 64'(vecs[i].g));
      chk($sformatf("vec%0d s_cyc", i), 64'(s_cyc), 64'(vecs[i].scyc));
      chk($sformatf("vec%0d ack", i), 64'(ack), 64'(vecs[i].a));
      chk($sformatf("vec%0d err", i), 64'(err), 64'(vecs[i].e));
      chk($sformatf("vec%0d s_adr", i), 64'(s_adr), 64'(x_adr));
    end

    // Single read by m1 at 0x4000_0000, acked three cycles after s_cyc rises.
    do_reset();
    @(negedge clk);
    adr[1] = 32'h4000_0000; sel[1] = 4'hF; we = 3'b000; cyc = 3'b010;
    #2;
    chk("single idle grant", 64'(grant), 64'(0));
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      #2;
      chk("single s_cyc", 64'(s_cyc), 64'(1));
      chk("single grant", 64'(grant), 64'(3'b010));
      chk("single s_adr", 64'(s_adr), 64'(32'h4000_0000));
      chk("single no ack", 64'(ack), 64'(0));
    end
    @(negedge clk);
    s_ack = 1'b1; s_rdt = 32'hDEAD_BEEF;
    #2;
    chk("single ack", 64'(ack), 64'(3'b010));
    chk("single rdt", 64'(rdt[1]), 64'(32'hDEAD_BEEF));
    @(negedge clk);
    s_ack = 1'b0; cyc = 3'b000;
    #2;
    chk("single grant after", 64'(grant), 64'(0));
    chk("single ack after", 64'(ack), 64'(0));

    // Reset asserted mid-transfer drops everything without a clock edge.
    do_reset();
    @(negedge clk);
    cyc = 3'b001;
    @(negedge clk);
    #2;
    chk("rstmid busy grant", 64'(grant), 64'(3'b001));
    chk("rstmid busy s_cyc", 64'(s_cyc), 64'(1));
    #1;
    rst_n = 1'b0;
    s_ack = 1'b1;
    #1;
    chk("rstmid s_cyc", 64'(s_cyc), 64'(0));
    chk("rstmid grant", 64'(grant), 64'(0));
    chk("rstmid ack_err", 64'({ack, err}), 64'(0));
    s_ack = 1'b0;
    repeat (2) @(negedge clk);
    cyc   = 3'b111;
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("rstmid first winner", 64'(grant), 64'(3'b001));

    // Randomized traffic against the reference model.
    do_reset();
    done = 3'b000;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      for (logic [1:0] n = 2'd0; n != 2'd3; n++) begin
        if (cyc[n]) begin
          if (done[n] && $urandom_range(0, 1) == 0) cyc[n] = 1'b0;
          else if (!done[n] && $urandom_range(0, 29) == 0) cyc[n] = 1'b0;
        end else begin
          adr[n] = $urandom;
          dat[n] = $urandom;
          sel[n] = 4'($urandom);
          we[n]  = 1'($urandom);
          if ($urandom_range(0, 2) == 0) cyc[n] = 1'b1;
        end
      end
      s_ack = ($urandom_range(0, 3) == 0);
      s_rdt = $urandom;
      #2;
      model_check();
      done = e_a | e_e;
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
